goomba_interaction_fsm: RTL

- Downstream consumer of the Goomba mover's goomba_x/goomba_y.
- Runs on movement_clock. Compares the Goomba bounding box against Mario's bounding box and resolves each contact as either a stomp (the Goomba is squashed) or a side hit (Mario is damaged).
- Drives the Goomba life-cycle FSM, the squash-sprite select, and single-cycle event pulses consumed by the Mario mover and the score/lives logic.

---
 rtl/goomba_interaction_fsm.sv | 122 ++++++++++++
 1 files changed

// File: rtl/goomba_interaction_fsm.sv
// Goomba life cycle: resolves Mario/Goomba contacts into stomps or side hits, and times the squash and hit cooldown.
// Outputs are registered, so a contact sampled on an edge shows up on the outputs right after that edge.
module goomba_interaction_fsm #(
    parameter int CHARACTER_WIDTH = 42,
    parameter int STOMP_MARGIN    = 12,
    parameter int SQUASH_TICKS    = 30,
    parameter int HIT_COOLDOWN    = 60
) (
    input  logic               movement_clock,
    input  logic               reset,
    input  logic signed [31:0] mario_x,
    input  logic signed [31:0] mario_y,
    input  logic               mario_falling,
    input  logic signed [31:0] goomba_x,
    input  logic signed [31:0] goomba_y,
    input  logic               respawn,
    output logic               goomba_alive,
    output logic               goomba_squashed,
    output logic               stomp_pulse,
    output logic               mario_hit_pulse,
    output logic               score_inc
);

    localparam int SQ_W = $clog2(SQUASH_TICKS + 1);
    localparam int CD_W = $clog2(HIT_COOLDOWN + 1);

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SQUASHED = 2'd1,
        DEAD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SQ_W-1:0]   squash_q, squash_d;
    logic [CD_W-1:0]   cool_q, cool_d;
    logic              stomp_d, hit_d;
    logic              alive_q, squashed_q, stomp_q, hit_q, score_q;

    logic              overlap, top_contact, stomp_cond, hit_cond;

    // Touching edges are not an overlap, hence the strict comparisons.
    always_comb begin
        overlap     = (mario_x < goomba_x + CHARACTER_WIDTH) &&
                      (goomba_x < mario_x + CHARACTER_WIDTH) &&
                      (mario_y < goomba_y + CHARACTER_WIDTH) &&
                      (goomba_y < mario_y + CHARACTER_WIDTH);
        top_contact = (mario_y + CHARACTER_WIDTH) <= (goomba_y + STOMP_MARGIN);
        stomp_cond  = overlap && mario_falling && top_contact;
        hit_cond    = overlap && !stomp_cond && (cool_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        cool_d   = (cool_q != '0) ? cool_q - 1'b1 : cool_q;
        stomp_d  = 1'b0;
        hit_d    = 1'b0;
        case (state_q)
            ALIVE: begin
                if (stomp_cond) begin
                    state_d  = SQUASHED;
                    squash_d = SQ_W'(SQUASH_TICKS - 1);
                    stomp_d  = 1'b1;
                end else if (hit_cond) begin
                    hit_d  = 1'b1;
                    cool_d = CD_W'(HIT_COOLDOWN);
                end
            end
            SQUASHED: begin
                // A respawn request takes precedence over the squash timer expiring.
                if (respawn) begin
                    state_d  = ALIVE;
                    squash_d = '0;
                end else if (squash_q == '0) begin
                    state_d = DEAD;
                end else begin
                    squash_d = squash_q - 1'b1;
                end
            end
            DEAD: begin
                if (respawn) begin
                    state_d = ALIVE;
                    cool_d  = '0;
                end
            end
            default: begin
                state_d  = ALIVE;
                squash_d = '0;
                cool_d   = '0;
            end
        endcase
    end

    always_ff @(posedge movement_clock or posedge reset) begin
        if (reset) begin
            state_q    <= ALIVE;
            squash_q   <= '0;
            cool_q     <= '0;
            alive_q    <= 1'b1;
            squashed_q <= 1'b0;
            stomp_q    <= 1'b0;
            hit_q      <= 1'b0;
            score_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            cool_q     <= cool_d;
            alive_q    <= (state_d == ALIVE);
            squashed_q <= (state_d == SQUASHED);
            stomp_q    <= stomp_d;
            hit_q      <= hit_d;
            score_q    <= stomp_d;
        end
    end

    assign goomba_alive    = alive_q;
    assign goomba_squashed = squashed_q;
    assign stomp_pulse     = stomp_q;
    assign mario_hit_pulse = hit_q;
    assign score_inc       = score_q;

endmodule
